fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `synchronous_fifo` write port between `NUM_REQ` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_en` and `data_in` directly. It sits between the producer agents/blocks and the FIFO instance, and watches the FIFO `full` flag for back-pressure.

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/rr_picker.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 77 +++++++
 tb/tb_fifo_wr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and default parameters for the FIFO write arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE, BURST} arb_state_t;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first valid requester after i_rr_ptr.
module rr_picker import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic                       o_pick_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_pick_id
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [ID_W-1:0] w_idx;
    // Scan farthest-first so the candidate nearest rr_ptr+1 is the last one written.
    always_comb begin
        o_pick_valid = 1'b0;
        o_pick_id    = '0;
        w_idx        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx        = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            o_pick_valid = i_req_valid[w_idx] ? 1'b1 : o_pick_valid;
            o_pick_id    = i_req_valid[w_idx] ? w_idx : o_pick_id;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers, with back-pressure from the FIFO full flag.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_w_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_data_in,
    output logic                          o_gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_gnt_id
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt, r_rr_ptr, w_rr_ptr_nxt, w_pick_id;
    logic [CNT_W-1:0] r_burst_cnt, w_cnt_nxt;
    logic             w_pick_valid, w_burst, w_own_valid, w_wr, w_done;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req_valid  (i_req_valid),
        .i_rr_ptr     (r_rr_ptr),
        .o_pick_valid (w_pick_valid),
        .o_pick_id    (w_pick_id)
    );

    assign w_burst     = r_state == BURST;
    assign w_own_valid = i_req_valid[r_owner];
    assign w_wr        = w_burst && w_own_valid && !i_fifo_full;
    // A stalled cycle neither counts nor ends the burst; a dropped valid always does.
    assign w_done      = !w_own_valid || (w_wr && r_burst_cnt == CNT_W'(MAX_BURST - 1));

    assign o_req_ready    = (w_burst && !i_fifo_full) ? NUM_REQ'(1) << r_owner : '0;
    assign o_fifo_w_en    = w_wr;
    assign o_fifo_data_in = w_wr ? i_req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_gnt_valid    = w_burst;
    assign o_gnt_id       = r_owner;

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_burst_cnt;
        if (!w_burst) begin
            w_state_nxt = w_pick_valid ? BURST : IDLE;
            w_owner_nxt = w_pick_valid ? w_pick_id : r_owner;
            w_cnt_nxt   = '0;
        end else if (w_done) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_owner;
            w_cnt_nxt    = '0;
        end else begin
            w_cnt_nxt = r_burst_cnt + CNT_W'(w_wr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus against a queue-based arbiter and FIFO model.
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 8, MB = 4, DEPTH = 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic [N-1:0]  i_req_valid = '0;
    logic [N*DW-1:0] i_req_data = '0;
    logic          i_fifo_full = 1'b0;
    logic [N-1:0]  o_req_ready;
    logic          o_fifo_w_en;
    logic [DW-1:0] o_fifo_data_in;
    logic          o_gnt_valid;
    logic [1:0]    o_gnt_id;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .i_fifo_full    (i_fifo_full),
        .o_fifo_w_en    (o_fifo_w_en),
        .o_fifo_data_in (o_fifo_data_in),
        .o_gnt_valid    (o_gnt_valid),
        .o_gnt_id       (o_gnt_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, n_wr = 0, n_hs = 0, c55;
    logic [DW-1:0] fifo_q[$], exp_q[$], rd_log[$];
    logic [N-1:0]  v;
    logic [DW-1:0] d[N], base[N];
    int            k[N], lim[N];
    bit            rnd, rd;
    int            m_own, m_last, m_gid, m_used;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh(input int i);
        v[i] = (k[i] < lim[i]) && (!rnd || $urandom_range(0, 2) != 0);
        d[i] = rnd ? DW'($urandom) : base[i] + DW'(k[i]);
    endtask

    task automatic setup(input bit r);
        rnd = r;
        fifo_q.delete();
        exp_q.delete();
        rd_log.delete();
        for (int i = 0; i < N; i++) begin
            k[i] = 0;
            refresh(i);
            i_req_data[i*DW +: DW] = d[i];
        end
        i_req_valid = v;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_w_en", 32'(o_fifo_w_en), 32'd0);
        chk("rst_data", 32'(o_fifo_data_in), 32'd0);
        chk("rst_gnt_valid", 32'(o_gnt_valid), 32'd0);
        chk("rst_gnt_id", 32'(o_gnt_id), 32'd0);
        m_own = -1;
        m_last = N - 1;
        m_gid = 0;
        m_used = 0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0]  e_rdy;
        logic          e_wen, a_wen;
        logic [DW-1:0] e_data, a_data, got, want;
        i_req_valid = v;
        for (int i = 0; i < N; i++) i_req_data[i*DW +: DW] = d[i];
        i_fifo_full = fifo_q.size() >= DEPTH;
        #1;
        e_rdy = '0;
        e_wen = 1'b0;
        e_data = '0;
        if (m_own >= 0 && !i_fifo_full) begin
            e_rdy[m_own] = 1'b1;
            e_wen = v[m_own];
            e_data = v[m_own] ? d[m_own] : '0;
        end
        chk("ready", 32'(o_req_ready), 32'(e_rdy));
        chk("w_en", 32'(o_fifo_w_en), 32'(e_wen));
        chk("data", 32'(o_fifo_data_in), 32'(e_data));
        chk("gnt_valid", 32'(o_gnt_valid), 32'(m_own >= 0));
        chk("gnt_id", 32'(o_gnt_id), 32'(m_gid));
        a_wen = o_fifo_w_en;
        a_data = o_fifo_data_in;
        n_wr += int'(a_wen);
        n_hs += $countones(v & o_req_ready);
        @(posedge clk);
        if (rd && fifo_q.size() > 0) begin
            got = fifo_q.pop_front();
            want = exp_q.size() > 0 ? exp_q.pop_front() : ~got;
            rd_log.push_back(got);
            chk("rd_order", 32'(got), 32'(want));
        end
        if (a_wen) fifo_q.push_back(a_data);
        if (e_wen) exp_q.push_back(e_data);
        if (m_own < 0) begin
            for (int j = 1; j <= N && m_own < 0; j++) begin
                int c = (m_last + j) % N;
                if (v[c]) m_own = c;
            end
            if (m_own >= 0) begin
                m_gid = m_own;
                m_used = 0;
            end
        end else if (!v[m_own] || (e_wen && m_used + 1 == MB)) begin
            m_last = m_own;
            m_own = -1;
        end else begin
            m_used += int'(e_wen);
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && e_rdy[i]) k[i]++;
            if (!(v[i] && !e_rdy[i])) refresh(i);
        end
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        // All producers streaming from reset: fixed burst rotation
        base = '{8'hA0, 8'h10, 8'h20, 8'h30};
        lim = '{100, 100, 100, 100};
        rd = 1'b1;
        setup(1'b0);
        do_reset();
        repeat (30) step();
        for (int j = 0; j < 16; j++)
            chk("t1_order", 32'(rd_log[j]), j < 4 ? 32'(8'hA0 + j) : 32'(16 * (j / 4) + j % 4));
        // Short burst then contention: last owner gets lowest priority
        base = '{8'h00, 8'h00, 8'h40, 8'h60};
        lim = '{0, 0, 2, 0};
        rd = 1'b0;
        setup(1'b0);
        do_reset();
        repeat (5) step();
        chk("t3_writes", 32'(fifo_q.size()), 32'd2);
        lim[2] = 6;
        lim[3] = 4;
        refresh(2);
        refresh(3);
        step();
        chk("t3_gnt_valid", 32'(o_gnt_valid), 32'd1);
        chk("t3_gnt_id", 32'(o_gnt_id), 32'd3);
        rd = 1'b1;
        repeat (12) step();
        // Back-pressure: FIFO full while producer 1 holds 0x55
        base = '{8'h00, 8'h4D, 8'h00, 8'h00};
        lim = '{0, 12, 0, 0};
        rd = 1'b0;
        setup(1'b0);
        do_reset();
        repeat (14) step();
        i_fifo_full = fifo_q.size() >= DEPTH;
        #1;
        chk("t4_level", 32'(fifo_q.size()), 32'd8);
        chk("t4_ready", 32'(o_req_ready), 32'd0);
        chk("t4_w_en", 32'(o_fifo_w_en), 32'd0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        repeat (3) step();
        c55 = 0;
        foreach (fifo_q[j]) c55 += int'(fifo_q[j] == 8'h55);
        chk("t4_once", 32'(c55), 32'd1);
        rd = 1'b1;
        repeat (20) step();
        // Reset in the middle of a burst
        base = '{8'hC0, 8'hD0, 8'hE0, 8'hF0};
        lim = '{40, 40, 40, 40};
        setup(1'b0);
        do_reset();
        repeat (3) step();
        do_reset();
        step();
        chk("t5_gnt_id", 32'(o_gnt_id), 32'd0);
        chk("t5_gnt_valid", 32'(o_gnt_valid), 32'd1);
        repeat (30) step();
        // Random valids, data and reads
        lim = '{100000, 100000, 100000, 100000};
        setup(1'b1);
        do_reset();
        repeat (3000) begin
            rd = bit'($urandom_range(0, 1));
            step();
        end
        rd = 1'b1;
        repeat (40) step();
        chk("drain_level", 32'(fifo_q.size()), 32'(exp_q.size()));
        chk("handshakes", 32'(n_wr), 32'(n_hs));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
